ipml_reg_fifo_v1_2_sync_fifo: RTL
=================================

IPML_REG_FIFO_V1_2_SYNC_FIFO -- requirements
Module: ipml_reg_fifo_v1_2_sync_fifo

Interface
REQ-001 SHALL have parameter W, default 8: data width in bits, W >= 1.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries, a power of 2, DEPTH >= 2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1: almost_full threshold, 1..DEPTH.
REQ-004 SHALL have parameter AE_LEVEL, default 1: almost_empty threshold, 0..DEPTH-1.
REQ-005 SHALL have port clk  input  1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-007 SHALL have port flush  input  1: synchronous discard of all contents.
REQ-008 SHALL have port data_in_valid  input  1: producer has a word on data_in.
REQ-009 SHALL have port data_in  input  W: write data.
REQ-010 SHALL have port data_in_ready  output  1: FIFO accepts a word this cycle.
REQ-011 SHALL have port data_out_ready  input  1: consumer takes data_out this cycle.
REQ-012 SHALL have port data_out  output  W: head-of-FIFO data.
REQ-013 SHALL have port data_out_valid  output  1: data_out holds a valid word.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1: number of stored words, 0..DEPTH.
REQ-015 SHALL have port almost_full  output  1: count >= AF_LEVEL.
REQ-016 SHALL have port almost_empty  output  1: count <= AE_LEVEL.

Function
REQ-017 SHALL define write = data_in_valid & data_in_ready and read = data_out_valid & data_out_ready.
REQ-018 SHALL drive data_in_ready = (count != DEPTH) & ~flush, with no combinational path from data_out_ready; a full FIFO stays not-ready even while it is being read.
REQ-019 SHALL drive data_out_valid = (count != 0) & ~flush.
REQ-020 SHALL store entries in a register array of DEPTH x W, with write pointer wptr and read pointer rptr of $clog2(DEPTH) bits.
REQ-021 SHALL, on write, load array[wptr] with data_in and increment wptr modulo DEPTH (natural wrap).
REQ-022 SHALL, on read, increment rptr modulo DEPTH.
REQ-023 SHALL drive data_out = array[rptr] combinationally (first-word-fall-through); data_out is don't-care while data_out_valid = 0.
REQ-024 SHALL give a write-to-data_out_valid latency of 1 cycle: a word written at edge N into an empty FIFO is valid after edge N.
REQ-025 SHALL update count: +1 on write only, -1 on read only, unchanged on simultaneous write and read, and unchanged when neither occurs.
REQ-026 SHALL preserve order: words leave in exactly the order accepted, with no loss or duplication across pointer wrap.
REQ-027 SHALL allow simultaneous write and read whenever 0 < count < DEPTH; count holds and both pointers advance.
REQ-028 SHALL ignore data_in_valid when full and data_out_ready when empty, changing no state.
REQ-029 SHALL, with flush high at an edge, set wptr = rptr = 0 and count = 0; flush takes priority over any write and read in that cycle (both are suppressed by REQ-018/019).
REQ-030 SHALL leave array contents unchanged on flush.
REQ-031 SHALL derive almost_full and almost_empty combinationally from the count register only.

Reset
REQ-032 SHALL, with rst high at an edge, clear wptr, rptr, count and every array entry to 0; rst overrides flush, write and read.
REQ-033 SHALL hold outputs during and after reset until the first write: data_in_ready=1, data_out_valid=0, data_out=0, count=0, almost_full=0 (for AF_LEVEL >= 1), almost_empty=1.
REQ-034 SHALL discard all contents when reset is asserted mid-operation, with no partial state surviving.

Verification (W=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-035 SHALL test fill: write 0x11,0x22,0x33,0x44 without reads -> count 1,2,3,4; almost_full=1 from count 3; data_in_ready=0 at count 4; 0x55 offered while full is not accepted.
REQ-036 SHALL test drain: from full, hold data_out_ready=1 -> data_out 0x11,0x22,0x33,0x44 on successive cycles, then data_out_valid=0, count=0, almost_empty=1.
REQ-037 SHALL test streaming: continuous valid and ready for 10 words 0x00..0x09 starting at count 1 -> count holds at 1, output order 0x00..0x09, pointers wrap twice without error.
REQ-038 SHALL test full+read: at count 4, assert data_in_valid and data_out_ready together -> only the read occurs, count=3; next cycle the write is accepted and count=3.
REQ-039 SHALL test flush: with count 2, assert flush together with a write of 0xAA -> data_in_ready=0 and data_out_valid=0 that cycle, then count=0 and 0xAA never appears at the output.
REQ-040 SHALL test reset: assert rst mid-stream at count 3 -> next cycle count=0, data_out_valid=0, data_out=0, data_in_ready=1, and a following write 0x5A is output first.

Source files
------------

// File: rtl/ipml_reg_fifo_v1_2_sync_fifo.sv
// Synchronous first-word-fall-through FIFO built on a register array, with flush,
// an occupancy count and almost_full/almost_empty flags taken from the count register.
module ipml_reg_fifo_v1_2_sync_fifo #(
  parameter int W        = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     data_in_valid,
  input  logic [W-1:0]             data_in,
  output logic                     data_in_ready,
  input  logic                     data_out_ready,
  output logic [W-1:0]             data_out,
  output logic                     data_out_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     almost_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count_r;
  logic          write;
  logic          read;

  // Handshakes depend only on registered state and flush, so a full FIFO
  // never becomes ready through a same-cycle read.
  assign data_in_ready  = (count_r != CW'(DEPTH)) & ~flush;
  assign data_out_valid = (count_r != '0) & ~flush;
  assign write          = data_in_valid & data_in_ready;
  assign read           = data_out_valid & data_out_ready;

  assign data_out     = mem[rptr];
  assign count        = count_r;
  assign almost_full  = (count_r >= CW'(AF_LEVEL));
  assign almost_empty = (count_r <= CW'(AE_LEVEL));

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // Contents are left in place; only the bookkeeping is cleared.
      wptr    <= '0;
      rptr    <= '0;
      count_r <= '0;
    end else begin
      if (write) begin
        mem[wptr] <= data_in;
        wptr      <= wptr + PW'(1);
      end
      if (read) begin
        rptr <= rptr + PW'(1);
      end
      case ({write, read})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule
